// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MEM and WB pipeline stages: the opcode constants,
// the rt/rd register-field positions inside an instruction word, and a small
// decoder that sorts an opcode into the classes the MEM stage cares about.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Register field positions, shared with WB for destination selection
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_LW    = 2'd1,
    CLS_SW    = 2'd2,
    CLS_ALU   = 2'd3   // addi and R-type: result passes straight through
  } op_class_e;

  function automatic op_class_e decode_op(input logic [5:0] opcode);
    op_class_e cls;
    case (opcode)
      OP_LW:    cls = CLS_LW;
      OP_SW:    cls = CLS_SW;
      OP_ADDI:  cls = CLS_ALU;
      OP_RTYPE: cls = CLS_ALU;
      default:  cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_dmem.sv
// -----------------------------------------------------------------------------
// mem_dmem
// Single-port word-addressed data RAM: synchronous write, combinational read,
// synchronous clear of every word.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   clr_i    - synchronous clear, zeroes every word (has priority over write)
//   we_i     - write enable
//   addr_i   - word address
//   wdata_i  - write data
//   rdata_o  - combinational read of the addressed word
// -----------------------------------------------------------------------------
module mem_dmem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Storage array: clear or write on the rising edge
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read is combinational so a load right after a store sees the new word
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM stage of a 5-stage MIPS pipeline: decodes the instruction leaving EX,
// performs lw/sw against the data RAM, and registers the instruction and the
// write-back value for WB. Accepts one instruction every cycle, no stalls.
// Ports:
//   clk             - clock
//   rst             - synchronous active-high reset (clears outputs and RAM)
//   EX_instruction  - instruction leaving EX
//   ALU_result      - EX result; byte address for lw/sw
//   EX_storedata    - rt value to store for sw
//   MEM_instruction - registered instruction for WB
//   Readdata        - registered write-back value for WB
//   store_count     - committed in-range stores, saturating at 16'hFFFF
//   misalign_err    - one-cycle pulse on a rejected misaligned lw/sw
// Configuration:
//   MEM_ALIGN_CHECK_EN - when defined, lw/sw with ALU_result[1:0] != 0 are
//                        turned into a NOP and flagged on misalign_err;
//                        otherwise the low address bits are ignored.
// -----------------------------------------------------------------------------
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_instruction,
  input  logic [31:0] ALU_result,
  input  logic [31:0] EX_storedata,
  output logic [31:0] MEM_instruction,
  output logic [31:0] Readdata,
  output logic [15:0] store_count,
  output logic        misalign_err
);

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  op_class_e   cls_s;
  logic        in_range_s;
  logic        misalign_s;
  logic        we_s;
  logic [31:0] rdata_s;

  logic [31:0] instr_d, instr_q;
  logic [31:0] rd_d, rd_q;
  logic [15:0] cnt_d, cnt_q;
  logic        mis_d, mis_q;

  assign cls_s      = decode_op(EX_instruction[31:26]);
  assign in_range_s = (ALU_result[31:AW+2] == '0);
  assign misalign_s = ALIGN_CHECK & ((cls_s == CLS_LW) | (cls_s == CLS_SW))
                      & (ALU_result[1:0] != 2'b00);
  // A store during reset is dropped; the RAM is being cleared anyway
  assign we_s       = (cls_s == CLS_SW) & in_range_s & ~misalign_s & ~rst;

  mem_dmem #(.DEPTH(DEPTH), .AW(AW)) u_dmem (
    .clk     (clk),
    .clr_i   (rst),
    .we_i    (we_s),
    .addr_i  (ALU_result[AW+1:2]),
    .wdata_i (EX_storedata),
    .rdata_o (rdata_s)
  );

  // Next-state for the MEM/WB register and the store counter
  always_comb begin
    instr_d = EX_instruction;
    rd_d    = 32'h0000_0000;
    cnt_d   = cnt_q;
    mis_d   = misalign_s;
    if (misalign_s) begin
      instr_d = 32'h0000_0000;
    end else begin
      case (cls_s)
        CLS_LW:  rd_d = in_range_s ? rdata_s : 32'h0000_0000;
        CLS_ALU: rd_d = ALU_result;
        default: rd_d = 32'h0000_0000;
      endcase
    end
    if (we_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // MEM/WB pipeline register and store counter
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= 32'h0000_0000;
      rd_q    <= 32'h0000_0000;
      cnt_q   <= 16'h0000;
      mis_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign MEM_instruction = instr_q;
  assign Readdata        = rd_q;
  assign store_count     = cnt_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_err    = mis_q;
`else
  assign misalign_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Randomised and directed stimulus for mem_stage. Each issued instruction is
// run through a word-array reference model and the expected MEM/WB outputs are
// queued; a monitor pops one entry per clock and compares.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] JMP  = 6'b000010;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EX_instruction, ALU_result, EX_storedata;
  logic [31:0] MEM_instruction, Readdata;
  logic [15:0] store_count;
  logic        misalign_err;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .EX_instruction  (EX_instruction),
    .ALU_result      (ALU_result),
    .EX_storedata    (EX_storedata),
    .MEM_instruction (MEM_instruction),
    .Readdata        (Readdata),
    .store_count     (store_count),
    .misalign_err    (misalign_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rd;
    logic [15:0] cnt;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: plain word array plus a store tally
  logic [31:0] mdl_mem [DEPTH];
  int          mdl_cnt;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd0, rt, 16'h0000};
  endfunction

  task automatic issue(input logic r, input logic [31:0] ins,
                       input logic [31:0] alu, input logic [31:0] sd);
    exp_t        e;
    logic [5:0]  op;
    bit          is_lw, is_sw, inr, mis;
    int          idx;
    @(negedge clk);
    rst = r; EX_instruction = ins; ALU_result = alu; EX_storedata = sd;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
      mdl_cnt = 0;
      e.instr = 32'h0; e.rd = 32'h0; e.cnt = 16'h0; e.mis = 1'b0;
    end else begin
      op    = ins[31:26];
      is_lw = (op == LW);
      is_sw = (op == SW);
      inr   = (alu < 32'(DEPTH * 4));
      idx   = int'((alu / 32'd4) % 32'(DEPTH));
      mis   = ALIGN_EN && (is_lw || is_sw) && (alu % 32'd4 != 32'd0);
      e.instr = mis ? 32'h0 : ins;
      e.mis   = mis;
      e.rd    = 32'h0;
      if (!mis) begin
        if (is_lw && inr) e.rd = mdl_mem[idx];
        else if (is_sw && inr) begin
          mdl_mem[idx] = sd;
          if (mdl_cnt < 65535) mdl_cnt++;
        end else if (op == ADDI || op == RTY) e.rd = alu;
      end
      e.cnt = 16'(mdl_cnt);
    end
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one output set per clock, compared against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("MEM_instruction", MEM_instruction, e.instr);
        chk("Readdata",        Readdata,        e.rd);
        chk("store_count",     {16'h0, store_count}, {16'h0, e.cnt});
        chk("misalign_err",    {31'h0, misalign_err}, {31'h0, e.mis});
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          sel;
    rst = 1'b1; EX_instruction = 32'h0; ALU_result = 32'h0; EX_storedata = 32'h0;

    // Reset, store, reset for two cycles (with a store during reset), reload
    issue(1'b1, 32'h0, 32'h0, 32'h0);
    issue(1'b0, mk(SW, 5'd9), 32'h10, 32'hDEADBEEF);
    issue(1'b0, mk(LW, 5'd8), 32'h10, 32'h0);
    issue(1'b1, mk(SW, 5'd9), 32'h10, 32'hDEADBEEF);
    issue(1'b1, 32'h0, 32'h0, 32'h0);
    issue(1'b0, mk(LW, 5'd8), 32'h10, 32'h0);

    // Store then immediate load of the same word
    issue(1'b0, mk(SW, 5'd9), 32'h08, 32'h12345678);
    issue(1'b0, mk(LW, 5'd8), 32'h08, 32'h0);

    // Pass-through and "other" opcodes
    issue(1'b0, mk(ADDI, 5'd3) | 32'h0000_FFFB, 32'hFFFFFFFB, 32'h0);
    issue(1'b0, mk(RTY, 5'd4) | 32'h0000_2020, 32'd7, 32'h0);
    issue(1'b0, mk(JMP, 5'd0) | 32'h0000_0040, 32'h55, 32'h0);

    // Out of range: byte address 0x100 is word 64 of a 64-word RAM
    issue(1'b0, mk(SW, 5'd9), 32'h100, 32'hCAFEF00D);
    issue(1'b0, mk(LW, 5'd8), 32'h100, 32'h0);
    issue(1'b0, mk(LW, 5'd8), 32'h0, 32'h0);

    // Misaligned store then read back word 1
    issue(1'b0, mk(SW, 5'd9), 32'h04, 32'h11111111);
    issue(1'b0, mk(SW, 5'd9), 32'h06, 32'hA5A5A5A5);
    issue(1'b0, mk(LW, 5'd8), 32'h04, 32'h0);
    issue(1'b0, mk(LW, 5'd8), 32'h07, 32'h0);

    // Random mix
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      else if (sel < 8) a = 32'($urandom_range(0, DEPTH * 4 - 1));
      else if (sel < 9) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000));
      else              a = $urandom();
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: issue(1'b0, mk(LW, 5'($urandom)), a, 32'h0);
        3, 4, 5: issue(1'b0, mk(SW, 5'($urandom)), a, $urandom());
        6:       issue(1'b0, mk(ADDI, 5'($urandom)) | 32'($urandom_range(0, 65535)), a, 32'h0);
        7:       issue(1'b0, mk(RTY, 5'($urandom)) | 32'($urandom_range(0, 65535)), a, 32'h0);
        8:       issue(1'b0, $urandom(), a, $urandom());
        default: issue($urandom_range(0, 19) == 0, mk(SW, 5'd1), a, $urandom());
      endcase
    end

    // Saturation: reset, bring the counter to 0xFFFE, then three more stores
    issue(1'b1, 32'h0, 32'h0, 32'h0);
    for (int n = 0; n < 65534; n++) begin
      issue(1'b0, mk(SW, 5'd2), 32'($urandom_range(0, DEPTH - 1)) * 32'd4, $urandom());
    end
    for (int n = 0; n < 3; n++) begin
      issue(1'b0, mk(SW, 5'd2), 32'h20, 32'(n));
    end
    issue(1'b0, mk(LW, 5'd3), 32'h20, 32'h0);

    // Drain with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
